// File: rtl/alu_chain_seq_if.sv
// Handshake and ALU-side bundle for alu_chain_seq: command in, shared ALU drive/return, result out.
// The slave modport is the block's own view; master is the environment (source, ALU, sink).
interface alu_chain_seq_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OPW-1:0]   in_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_out, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_data, out_err, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_op, alu_out, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_data, out_err, busy
    );
endinterface

// File: rtl/alu_chain_seq.sv
// Runs the 4-pass chain t1=f(A,B), t2=f(t1,B), t3=f(t1,t2), OUT=f(t3,t2) on one shared
// combinational ALU, one pass per cycle, between a valid/ready source and sink.
module alu_chain_seq #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 5,
    parameter int OP_MAX = 6
) (
    input logic            clk,
    input logic            rst,
    alu_chain_seq_if.slave io_bus
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        P2,
        P3,
        P4,
        DONE
    } state_t;

    state_t           r_state;
    logic             r_inReady;
    logic             r_outValid;
    logic             r_outErr;
    logic [WIDTH-1:0] r_outData;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_t1;
    logic [WIDTH-1:0] r_t2;
    logic [WIDTH-1:0] r_aluA;
    logic [WIDTH-1:0] r_aluB;
    logic [OPW-1:0]   r_aluOp;
    logic             w_accept;
    logic             w_illegalOp;

    assign w_accept    = io_bus.in_valid && r_inReady;
    assign w_illegalOp = (io_bus.in_op > OPW'(OP_MAX));

    // ALU operands are registered one pass ahead, so r_aluA/r_aluB already hold t3/t2 during P4
    // and the opcode register doubles as the latched command opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_outErr   <= 1'b0;
            r_outData  <= '0;
            r_b        <= '0;
            r_t1       <= '0;
            r_t2       <= '0;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_aluOp    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_inReady <= 1'b0;
                        r_b       <= io_bus.in_b;
                        if (w_illegalOp) begin
                            r_outErr   <= 1'b1;
                            r_outData  <= '0;
                            r_outValid <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_aluA  <= io_bus.in_a;
                            r_aluB  <= io_bus.in_b;
                            r_aluOp <= io_bus.in_op;
                            r_state <= P1;
                        end
                    end
                end
                P1: begin
                    r_t1    <= io_bus.alu_out;
                    r_aluA  <= io_bus.alu_out;
                    r_aluB  <= r_b;
                    r_state <= P2;
                end
                P2: begin
                    r_t2    <= io_bus.alu_out;
                    r_aluA  <= r_t1;
                    r_aluB  <= io_bus.alu_out;
                    r_state <= P3;
                end
                P3: begin
                    r_aluA  <= io_bus.alu_out;
                    r_aluB  <= r_t2;
                    r_state <= P4;
                end
                P4: begin
                    r_outData  <= io_bus.alu_out;
                    r_outValid <= 1'b1;
                    r_aluA     <= '0;
                    r_aluB     <= '0;
                    r_aluOp    <= '0;
                    r_state    <= DONE;
                end
                DONE: begin
                    if (io_bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_outErr   <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.in_ready  = r_inReady;
    assign io_bus.alu_a     = r_aluA;
    assign io_bus.alu_b     = r_aluB;
    assign io_bus.alu_op    = r_aluOp;
    assign io_bus.out_valid = r_outValid;
    assign io_bus.out_data  = r_outData;
    assign io_bus.out_err   = r_outErr;
    assign io_bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_chain_seq.sv
// Directed bench for alu_chain_seq, paired with a reference combinational ALU model.
module tb_alu_chain_seq;

    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testCount = 0;
    int   failCount = 0;
    bit   sawBadOp = 1'b0;

    alu_chain_seq_if #(.WIDTH(32), .OPW(5)) bus ();

    alu_chain_seq #(.WIDTH(32), .OPW(5), .OP_MAX(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU that the block time-multiplexes.
    always_comb begin
        case (bus.alu_op)
            5'd1:    bus.alu_out = bus.alu_a + bus.alu_b;
            5'd2:    bus.alu_out = bus.alu_a - bus.alu_b;
            5'd3:    bus.alu_out = bus.alu_a & bus.alu_b;
            5'd4:    bus.alu_out = bus.alu_a | bus.alu_b;
            5'd5:    bus.alu_out = bus.alu_a ^ bus.alu_b;
            5'd6:    bus.alu_out = ~(bus.alu_a | bus.alu_b);
            default: bus.alu_out = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.alu_op == 5'h1F) sawBadOp = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
    endtask

    // Issue one command, scramble inputs after accept, and measure accept-edge-to-valid latency.
    task automatic runChain(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] op, input logic [31:0] expData, input logic expErr,
                            input int expLat, input bit doRelease);
        int lat;
        applyStimulus(a, b, op);
        tick();
        lat = 1;
        bus.in_valid = 1'b0;
        bus.in_a     = 32'hDEAD_BEEF;
        bus.in_b     = 32'h1234_5678;
        bus.in_op    = OP_XOR;
        while (!bus.out_valid && lat < 12) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_data"}, bus.out_data, expData);
        checkOutput({tag, "_err"}, 32'(bus.out_err), 32'(expErr));
        if (doRelease) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            checkOutput({tag, "_validClear"}, 32'(bus.out_valid), 32'd0);
            checkOutput({tag, "_readyBack"}, 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        int acc2;
        bit willAccept;
        bit gotFirst;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_inReady", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_outValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_outData", bus.out_data, 32'd0);
        checkOutput("rst_outErr", 32'(bus.out_err), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_aluA", bus.alu_a, 32'd0);
        checkOutput("rst_aluOp", 32'(bus.alu_op), 32'd0);
        rst = 1'b0;
        tick();

        // ADD 1,2 pass by pass: 3, 5, 8, 13.
        applyStimulus(32'd1, 32'd2, OP_ADD);
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = 32'd99;
        checkOutput("add_inReady", 32'(bus.in_ready), 32'd0);
        checkOutput("add_busy", 32'(bus.busy), 32'd1);
        checkOutput("add_p1A", bus.alu_a, 32'd1);
        checkOutput("add_p1B", bus.alu_b, 32'd2);
        checkOutput("add_p1Op", 32'(bus.alu_op), 32'(OP_ADD));
        tick();
        checkOutput("add_p2A", bus.alu_a, 32'd3);
        checkOutput("add_p2B", bus.alu_b, 32'd2);
        tick();
        checkOutput("add_p3A", bus.alu_a, 32'd3);
        checkOutput("add_p3B", bus.alu_b, 32'd5);
        tick();
        checkOutput("add_p4A", bus.alu_a, 32'd8);
        checkOutput("add_p4B", bus.alu_b, 32'd5);
        checkOutput("add_notYetValid", 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput("add_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("add_data", bus.out_data, 32'd13);
        checkOutput("add_err", 32'(bus.out_err), 32'd0);
        checkOutput("add_doneAluOp", 32'(bus.alu_op), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("add_validClear", 32'(bus.out_valid), 32'd0);
        checkOutput("add_idle", 32'(bus.busy), 32'd0);

        runChain("sub", 32'd10, 32'd3, OP_SUB, 32'hFFFF_FFFF, 1'b0, 5, 1'b1);

        // XOR with a stalled sink; in_valid pulses meanwhile must be ignored.
        runChain("xor", 32'hF0, 32'h0F, OP_XOR, 32'hFF, 1'b0, 5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'd7, 32'd7, OP_ADD);
            tick();
            checkOutput("xor_stallValid", 32'(bus.out_valid), 32'd1);
            checkOutput("xor_stallData", bus.out_data, 32'hFF);
            checkOutput("xor_stallInReady", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("xor_validClear", 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput("xor_pulseIgnored", 32'(bus.busy), 32'd0);

        runChain("illegal", 32'h55, 32'hAA, 5'h1F, 32'd0, 1'b1, 1, 1'b1);
        checkOutput("illegal_errCleared", 32'(bus.out_err), 32'd0);
        checkOutput("illegal_noBadOp", 32'(sawBadOp), 32'd0);

        // Reset in P3 aborts the chain.
        applyStimulus(32'd1, 32'd2, OP_ADD);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_outValid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_inReady", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        runChain("afterAbort", 32'd1, 32'd2, OP_ADD, 32'd13, 1'b0, 5, 1'b1);

        // Back-to-back AND then OR with the sink always ready.
        bus.out_ready = 1'b1;
        applyStimulus(32'hFFFF, 32'hFF, OP_AND);
        tick();
        applyStimulus(32'd1, 32'd2, OP_OR);
        acc2 = -1;
        gotFirst = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            willAccept = bus.in_ready;
            tick();
            if (bus.out_valid && !gotFirst) begin
                checkOutput("b2b_andData", bus.out_data, 32'hFF);
                gotFirst = 1'b1;
            end
            if (willAccept) begin
                acc2 = cyc;
                break;
            end
        end
        checkOutput("b2b_firstSeen", 32'(gotFirst), 32'd1);
        checkOutput("b2b_acceptGap", 32'(acc2), 32'd6);
        bus.in_valid = 1'b0;
        gotFirst = 1'b0;
        for (int cyc = 0; cyc < 12 && !gotFirst; cyc++) begin
            tick();
            if (bus.out_valid) begin
                checkOutput("b2b_orData", bus.out_data, 32'h3);
                gotFirst = 1'b1;
            end
        end
        checkOutput("b2b_secondSeen", 32'(gotFirst), 32'd1);
        bus.out_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
